// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between NREQ byte sources
// Optional packet lock (requester keeps the channel until lastin) is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clkin,
    input  logic                 rstnin,
    input  logic [NREQ-1:0]      reqin,
    input  logic [8*NREQ-1:0]    datain,
    input  logic [NREQ-1:0]      lastin,
    output logic [NREQ-1:0]      ackout,
    output logic [NREQ-1:0]      grantout,
    output logic                 busyout,
    output logic [7:0]           uart_txdataout,
    output logic                 uart_txrdyout,
    input  logic                 uart_txrdyin
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAITHIGH = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [PW-1:0]     owner, owner_nxt;
    logic              lock, lock_nxt;
    logic [NREQ-1:0]   ack_nxt, grant_nxt, elig;
    logic [7:0]        data_nxt;
    logic              rdy_nxt;
    logic [PW-1:0]     win, idx;
    logic              win_vld;

    assign elig = lock ? (reqin & (NREQ'(1) << owner)) : reqin;

    // Walk from ptr+NREQ down to ptr+1 so the closest eligible requester after ptr wins last.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (elig[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        lock_nxt  = lock;
        ack_nxt   = '0;
        grant_nxt = grantout;
        data_nxt  = uart_txdataout;
        rdy_nxt   = uart_txrdyout;
        case (state)
            IDLE: begin
                if (uart_txrdyin && win_vld) begin
                    data_nxt  = datain[8*int'(win) +: 8];
                    ack_nxt   = NREQ'(1) << win;
                    grant_nxt = NREQ'(1) << win;
                    ptr_nxt   = win;
                    rdy_nxt   = 1'b1;
                    state_nxt = ISSUE;
`ifdef UART_ARB_LOCK_EN
                    lock_nxt  = ~lastin[win];
                    owner_nxt = win;
`endif
                end
            end
            ISSUE: begin
                if (!uart_txrdyin) begin
                    rdy_nxt   = 1'b0;
                    state_nxt = WAITHIGH;
                end
            end
            WAITHIGH: begin
                if (uart_txrdyin) begin
                    state_nxt = IDLE;
                    if (!lock) grant_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifndef UART_ARB_LOCK_EN
    logic unused_lastin;
    assign unused_lastin = ^lastin;
`endif

    always_ff @(posedge clkin or negedge rstnin) begin
        if (!rstnin) begin
            state          <= IDLE;
            ptr            <= PW'(NREQ - 1);
            owner          <= '0;
            lock           <= 1'b0;
            ackout         <= '0;
            grantout       <= '0;
            busyout        <= 1'b0;
            uart_txdataout <= 8'h00;
            uart_txrdyout  <= 1'b0;
        end else begin
            state          <= state_nxt;
            ptr            <= ptr_nxt;
            owner          <= owner_nxt;
            lock           <= lock_nxt;
            ackout         <= ack_nxt;
            grantout       <= grant_nxt;
            busyout        <= (state_nxt != IDLE);
            uart_txdataout <= data_nxt;
            uart_txrdyout  <= rdy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a behavioural UART and round-robin model
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int CPB   = 8;
    localparam int FRAME = 10 * CPB;

    logic                clkin = 1'b0;
    logic                rstnin = 1'b0;
    logic [NREQ-1:0]     reqin = '0;
    logic [NREQ-1:0]     lastin = '0;
    logic [8*NREQ-1:0]   datain = '0;
    logic [NREQ-1:0]     ackout, grantout;
    logic                busyout;
    logic [7:0]          uart_txdataout;
    logic                uart_txrdyout;

    logic                uart_rdy = 1'b1;
    logic                uart_acc = 1'b0;
    logic                frame_skip = 1'b0;
    logic [7:0]          uart_cap = 8'h00;
    int                  uart_cnt = 0;

    always #5 clkin = ~clkin;

    uart_tx_arbiter #(.NREQ(NREQ)) dut (
        .clkin          (clkin),
        .rstnin         (rstnin),
        .reqin          (reqin),
        .datain         (datain),
        .lastin         (lastin),
        .ackout         (ackout),
        .grantout       (grantout),
        .busyout        (busyout),
        .uart_txdataout (uart_txdataout),
        .uart_txrdyout  (uart_txrdyout),
        .uart_txrdyin   (uart_rdy)
    );

    // Transmitter: idle-high ready, accepts a strobe, stays busy for one 10-bit frame; not reset by rstnin.
    always @(posedge clkin) begin
        uart_acc <= 1'b0;
        if (uart_rdy) begin
            if (uart_txrdyout) begin
                uart_rdy   <= 1'b0;
                uart_cnt   <= FRAME - 1;
                uart_cap   <= uart_txdataout;
                uart_acc   <= 1'b1;
                frame_skip <= 1'b0;
            end
        end else if (uart_cnt == 0) begin
            uart_rdy <= 1'b1;
        end else begin
            uart_cnt <= uart_cnt - 1;
        end
        if (!rstnin) frame_skip <= 1'b1;
    end

    logic [10:0] exp_q[$];
    logic [8:0]  rq[NREQ][$];
    logic [8:0]  mq[NREQ][$];
    int          m_last = NREQ - 1;
    bit          m_locked = 1'b0;
    int          m_owner = 0;

    int n_chk = 0, n_fail = 0;
    int tmo_raised = 0, tmo_seen = 0;
    int fin_req = 0, fin_seen = 0;

    logic [NREQ-1:0] prev_ack = '0;
    logic            prev_rdy = 1'b0;
    int              strobe_w = 0;
    int              ack_since = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clkin) begin
        logic [10:0] e;
        int w;
        if (tmo_raised != tmo_seen) begin
            chk("wait_bound", tmo_raised, tmo_seen);
            tmo_seen = tmo_raised;
        end
        if (!rstnin) begin
            chk("reset_outputs", int'({ackout, grantout, busyout, uart_txdataout, uart_txrdyout}), 0);
            prev_ack  = '0;
            prev_rdy  = 1'b0;
            strobe_w  = 0;
            ack_since = 0;
        end else begin
            if (ackout != '0) begin
                chk("ack_onehot", $countones(ackout), 1);
                chk("ack_single_cycle", int'(prev_ack), 0);
                chk("grant_matches_ack", int'(grantout), int'(ackout));
                chk("busy_on_ack", int'(busyout), 1);
                w = 0;
                for (int i = 0; i < NREQ; i++) if (ackout[i]) w = i;
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", w, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("winner", w, int'(e[10:8]));
                    chk("byte", int'(uart_txdataout), int'(e[7:0]));
                end
                ack_since++;
            end
            if (uart_txrdyout && !prev_rdy) chk("strobe_while_uart_busy", int'(uart_rdy), 1);
            if (uart_txrdyout) begin
                strobe_w++;
            end else if (prev_rdy) begin
                chk("strobe_width", strobe_w, 2);
                strobe_w = 0;
            end
            if (uart_acc) begin
                chk("acks_per_frame", ack_since, 1);
                ack_since = 0;
            end
            if (!uart_rdy && !frame_skip) chk("data_stable", int'(uart_txdataout), int'(uart_cap));
`ifndef UART_ARB_LOCK_EN
            if (!busyout) chk("grant_idle", int'(grantout), 0);
`endif
            prev_ack = ackout;
            prev_rdy = uart_txrdyout;
        end
        if (fin_req != fin_seen) begin
            chk("scoreboard_empty", exp_q.size(), 0);
            fin_seen = fin_req;
        end
    end

    // Service order of everything pending: round robin after the last winner, lock pins the owner.
    task automatic model_drain();
        int   w;
        bit   found;
        bit   more = 1'b1;
        logic [8:0] ent;
        while (more) begin
            found = 1'b0;
            w = 0;
            if (m_locked) begin
                if (mq[m_owner].size() > 0) begin
                    w = m_owner;
                    found = 1'b1;
                end
            end else begin
                for (int k = 1; k <= NREQ && !found; k++) begin
                    if (mq[(m_last + k) % NREQ].size() > 0) begin
                        w = (m_last + k) % NREQ;
                        found = 1'b1;
                    end
                end
            end
            if (!found) begin
                more = 1'b0;
            end else begin
                ent = mq[w].pop_front();
                exp_q.push_back({3'(w), ent[7:0]});
                m_last = w;
`ifdef UART_ARB_LOCK_EN
                m_locked = ~ent[8];
                m_owner  = w;
`endif
            end
        end
    endtask

    task automatic add(input int i, input logic [7:0] b, input logic last);
        rq[i].push_back({last, b});
        mq[i].push_back({last, b});
    endtask

    task automatic drive();
        logic [8:0] h;
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
                h = rq[i][0];
                reqin[i]         = 1'b1;
                datain[8*i +: 8] = h[7:0];
                lastin[i]        = h[8];
            end else begin
                reqin[i]         = 1'b0;
                datain[8*i +: 8] = 8'h00;
                lastin[i]        = 1'b0;
            end
        end
    endtask

    task automatic step(output logic [NREQ-1:0] a);
        @(negedge clkin);
        a = ackout;
        @(posedge clkin);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (a[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        drive();
    endtask

    function automatic bit all_empty();
        bit r = 1'b1;
        for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) r = 1'b0;
        return r;
    endfunction

    task automatic run_idle(input int budget);
        logic [NREQ-1:0] a;
        int n = 0;
        bit idle = 1'b0;
        while (!idle && n < budget) begin
            step(a);
            n++;
            idle = (exp_q.size() == 0) && all_empty() && uart_rdy && !busyout;
        end
        if (!idle) tmo_raised++;
    endtask

    task automatic wait_ack(input int i, input int budget);
        logic [NREQ-1:0] a;
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < budget) begin
            step(a);
            n++;
            hit = a[i];
        end
        if (!hit) tmo_raised++;
    endtask

    task automatic load();
        model_drain();
        drive();
    endtask

    initial begin
        logic [NREQ-1:0] a;
        int n;
        rstnin = 1'b0;
        repeat (3) @(posedge clkin);
        #1;
        rstnin = 1'b1;
        repeat (2) step(a);

        add(0, 8'hA5, 1'b1);
        load();
        run_idle(400);

        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < 3; j++) add(i, 8'($urandom), j == 2);
        load();
        run_idle(2000);

        add(1, 8'($urandom), 1'b1);
        load();
        wait_ack(1, 100);
        repeat (3) step(a);
        add(2, 8'($urandom), 1'b1);
        load();
        run_idle(600);

        add(1, 8'h11, 1'b0);
        add(1, 8'h22, 1'b0);
        add(1, 8'h33, 1'b1);
        add(0, 8'h44, 1'b1);
        load();
        run_idle(1500);

        add(2, 8'($urandom), 1'b1);
        load();
        wait_ack(2, 100);
        repeat (4) step(a);
        rstnin   = 1'b0;
        m_last   = NREQ - 1;
        m_locked = 1'b0;
        repeat (2) step(a);
        rstnin = 1'b1;
        add(3, 8'($urandom), 1'b1);
        add(0, 8'($urandom), 1'b1);
        load();
        run_idle(800);

        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < NREQ; i++) begin
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) add(i, 8'($urandom), (j == n - 1) || ($urandom_range(0, 1) == 1));
            end
            load();
            run_idle(3000);
        end

        fin_req = 1;
        repeat (2) @(negedge clkin);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
